// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter.
package mem_arb_pkg;

    function automatic int REQ_ID_W(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// Tag FIFO holding requester ids of outstanding transactions; registered, zero-latency read of head.
// Push is ignored when full and pop when empty; extra pointer bit distinguishes full from empty.
module mem_arb_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i && !full_o) begin
            mem_d[wr_ptr_q[AW-1:0]] = data_i;
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (pop_i && !empty_o) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one OBI data port among NUM_REQ requesters; grant and response routing are combinational.
// Round-robin by default; defining MEM_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_REQ-1:0]           req_i,
    output logic [NUM_REQ-1:0]           gnt_o,
    input  logic [NUM_REQ*ADDR_W-1:0]    addr_i,
    input  logic [NUM_REQ-1:0]           we_i,
    input  logic [NUM_REQ*DATA_W/8-1:0]  be_i,
    input  logic [NUM_REQ*DATA_W-1:0]    wdata_i,
    output logic [NUM_REQ-1:0]           rvalid_o,
    output logic [NUM_REQ-1:0]           err_o,
    output logic [DATA_W-1:0]            rdata_o,
    output logic                         mem_req_o,
    output logic [ADDR_W-1:0]            mem_addr_o,
    output logic                         mem_we_o,
    output logic [DATA_W/8-1:0]          mem_be_o,
    output logic [DATA_W-1:0]            mem_wdata_o,
    input  logic                         mem_gnt_i,
    input  logic                         mem_rvalid_i,
    input  logic                         mem_err_i,
    input  logic [DATA_W-1:0]            mem_rdata_i,
    output logic                         spurious_o
);
    localparam int ID_W = REQ_ID_W(NUM_REQ);
    localparam int BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
    logic [BE_W-1:0]   be_arr    [NUM_REQ];
    logic [DATA_W-1:0] wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = addr_i[g*ADDR_W +: ADDR_W];
        assign be_arr[g]    = be_i[g*BE_W +: BE_W];
        assign wdata_arr[g] = wdata_i[g*DATA_W +: DATA_W];
    end

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  lock_idx_q, lock_idx_d;
    logic             spurious_q, spurious_d;
    logic [ID_W-1:0]  scan_base;
    logic [ID_W-1:0]  win_idx, sel_idx, head_id;
    logic             win_found, grant_fire, resp_fire;
    logic             fifo_full, fifo_empty;
    logic [NUM_REQ-1:0] eligible;

    // Full blocks issue outright, even when a response pops in the same cycle.
    assign eligible = req_i & {NUM_REQ{~fifo_full}};

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        win_found  = 1'b0;
        win_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && eligible[i] && (ID_W'(i) >= scan_base)) begin
                win_found = 1'b1;
                win_idx   = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && eligible[i]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(i);
            end
        end

        sel_idx    = (state_q == ARB_LOCKED) ? lock_idx_q : win_idx;
        mem_req_o  = (state_q == ARB_LOCKED) || win_found;
        grant_fire = mem_req_o && mem_gnt_i;

        if (state_q == ARB_IDLE && win_found && !mem_gnt_i) begin
            state_d    = ARB_LOCKED;
            lock_idx_d = win_idx;
        end else if (state_q == ARB_LOCKED && mem_gnt_i) begin
            state_d = ARB_IDLE;
        end

        gnt_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_o[i] = grant_fire && (sel_idx == ID_W'(i));
        end

        resp_fire = mem_rvalid_i && !fifo_empty;
        rvalid_o  = '0;
        err_o     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (resp_fire && (head_id == ID_W'(i))) begin
                rvalid_o[i] = 1'b1;
                err_o[i]    = mem_err_i;
            end
        end

        spurious_d = spurious_q | (mem_rvalid_i && fifo_empty);
    end

    assign mem_addr_o  = addr_arr[sel_idx];
    assign mem_we_o    = we_i[sel_idx];
    assign mem_be_o    = be_arr[sel_idx];
    assign mem_wdata_o = wdata_arr[sel_idx];
    assign rdata_o     = mem_rdata_i;
    assign spurious_o  = spurious_q;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign scan_base = '0;
`else
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_fire) begin
            rr_ptr_d = (sel_idx == ID_W'(NUM_REQ - 1)) ? '0 : sel_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rr_ptr_q <= '0;
        else         rr_ptr_q <= rr_ptr_d;
    end

    assign scan_base = rr_ptr_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ARB_IDLE;
            lock_idx_q <= '0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            spurious_q <= spurious_d;
        end
    end

    mem_arb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ID_W)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (grant_fire),
        .pop_i   (resp_fire),
        .data_i  (sel_idx),
        .data_o  (head_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (NUM_REQ=2, depth 4, 32-bit); expectations follow MEM_ARB_FIXED_PRIO_EN.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [1:0]  req_i, we_i, gnt_o, rvalid_o, err_o;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [3:0]  be [2];
    logic [63:0] addr_i, wdata_i;
    logic [7:0]  be_i;
    logic [31:0] rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, mem_err_i, spurious_o;
    logic [3:0]  mem_be_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    assign addr_i  = {addr[1], addr[0]};
    assign wdata_i = {wdata[1], wdata[0]};
    assign be_i    = {be[1], be[0]};

    mem_port_arbiter dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
        .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
        .rvalid_o(rvalid_o), .err_o(err_o), .rdata_o(rdata_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i),
        .spurious_o(spurious_o)
    );

    // A requester stalled in the address phase must keep its request up.
    always @(negedge clk_i) begin
        if (rst_ni && dut.state_q == ARB_LOCKED) begin
            checks++;
            assert (req_i[dut.lock_idx_q] === 1'b1) else begin
                failures++;
                $error("FAIL req_hold observed=%b required=1", req_i[dut.lock_idx_q]);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic clear_inputs();
        req_i = '0; we_i = '0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_err_i = 0;
        mem_rdata_i = '0;
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0; wdata[i] = '0; be[i] = 4'hF;
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        clear_inputs();
        settle();
        cyc();
        rst_ni = 1'b1;
    endtask

    logic [1:0] exp_order [4];

    initial begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_order = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        rst_ni = 1'b0;
        clear_inputs();
        settle();
        chk("rst_gnt", gnt_o, 0);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_spurious", spurious_o, 0);
        cyc();
        cyc();
        rst_ni = 1'b1;

        // Single requester read, latency 1
        req_i = 2'b01; addr[0] = 32'h100; mem_gnt_i = 1;
        settle();
        chk("rd_gnt", gnt_o, 2'b01);
        chk("rd_mem_req", mem_req_o, 1);
        chk("rd_mem_addr", mem_addr_o, 32'h100);
        chk("rd_mem_we", mem_we_o, 0);
        cyc();
        req_i = 2'b00; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
        settle();
        chk("rd_rvalid", rvalid_o, 2'b01);
        chk("rd_rdata", rdata_o, 32'hDEADBEEF);
        chk("rd_err", err_o, 0);
        cyc();
        mem_rvalid_i = 0;
        settle();
        chk("rd_idle_rvalid", rvalid_o, 0);
        chk("rd_idle_req", mem_req_o, 0);
        cyc();

        // Contention: both requesters held for four grants, then drain
        do_reset();
        addr[0] = 32'hA0; addr[1] = 32'hB0;
        for (int c = 0; c < 4; c++) begin
            req_i = 2'b11; mem_gnt_i = 1;
            settle();
            chk($sformatf("cont_gnt%0d", c), gnt_o, exp_order[c]);
            chk($sformatf("cont_addr%0d", c), mem_addr_o, exp_order[c] == 2'b01 ? 32'hA0 : 32'hB0);
            cyc();
        end
        for (int c = 0; c < 4; c++) begin
            req_i = 2'b00; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h10 + c;
            settle();
            chk($sformatf("cont_rvalid%0d", c), rvalid_o, exp_order[c]);
            cyc();
        end
        mem_rvalid_i = 0;

        // Lock: grant withheld 3 cycles, req1 rises during the stall
        do_reset();
        addr[0] = 32'h200; addr[1] = 32'h300;
        for (int c = 0; c < 3; c++) begin
            req_i = (c == 0) ? 2'b01 : 2'b11; mem_gnt_i = 0;
            settle();
            chk($sformatf("lock_addr%0d", c), mem_addr_o, 32'h200);
            chk($sformatf("lock_gnt%0d", c), gnt_o, 0);
            chk($sformatf("lock_req%0d", c), mem_req_o, 1);
            cyc();
        end
        req_i = 2'b11; mem_gnt_i = 1;
        settle();
        chk("lock_gnt_first", gnt_o, 2'b01);
        chk("lock_addr_first", mem_addr_o, 32'h200);
        cyc();
        req_i = 2'b10; mem_gnt_i = 1;
        settle();
        chk("lock_gnt_second", gnt_o, 2'b10);
        chk("lock_addr_second", mem_addr_o, 32'h300);
        cyc();
        req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
        settle();
        chk("lock_resp0", rvalid_o, 2'b01);
        cyc();
        settle();
        chk("lock_resp1", rvalid_o, 2'b10);
        cyc();
        mem_rvalid_i = 0;

        // Full FIFO: depth 4, memory latency 10, req0 streams
        do_reset();
        addr[0] = 32'h40;
        for (int c = 0; c < 10; c++) begin
            req_i = 2'b01; mem_gnt_i = 1; mem_rvalid_i = 0;
            settle();
            chk($sformatf("full_gnt%0d", c), gnt_o, (c < 4) ? 2'b01 : 2'b00);
            if (c == 4) chk("full_mem_req", mem_req_o, 0);
            cyc();
        end
        mem_rvalid_i = 1; mem_rdata_i = 32'hF0;
        settle();
        chk("full_pop_blocks_gnt", gnt_o, 0);
        chk("full_first_resp", rvalid_o, 2'b01);
        cyc();
        settle();
        chk("full_fifth_gnt", gnt_o, 2'b01);
        chk("full_push_pop_resp", rvalid_o, 2'b01);
        cyc();
        for (int c = 0; c < 3; c++) begin
            req_i = 0;
            settle();
            chk($sformatf("full_drain%0d", c), rvalid_o, 2'b01);
            cyc();
        end
        mem_rvalid_i = 0; mem_gnt_i = 0;
        settle();
        chk("full_spurious_clear", spurious_o, 0);
        cyc();

        // Mixed: req0 read interleaved with req1 write that errors
        do_reset();
        addr[0] = 32'h500; addr[1] = 32'h400; we_i = 2'b10; wdata[1] = 32'h55; be[1] = 4'h3;
        req_i = 2'b11; mem_gnt_i = 1;
        settle();
        chk("mix_gnt0", gnt_o, 2'b01);
        chk("mix_we0", mem_we_o, 0);
        cyc();
        req_i = 2'b10;
        settle();
        chk("mix_gnt1", gnt_o, 2'b10);
        chk("mix_we1", mem_we_o, 1);
        chk("mix_wdata1", mem_wdata_o, 32'h55);
        chk("mix_be1", mem_be_o, 4'h3);
        chk("mix_addr1", mem_addr_o, 32'h400);
        cyc();
        req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_err_i = 0; mem_rdata_i = 32'h1234;
        settle();
        chk("mix_rvalid_rd", rvalid_o, 2'b01);
        chk("mix_err_rd", err_o, 0);
        chk("mix_rdata_rd", rdata_o, 32'h1234);
        cyc();
        mem_err_i = 1;
        settle();
        chk("mix_rvalid_wr", rvalid_o, 2'b10);
        chk("mix_err_wr", err_o, 2'b10);
        cyc();
        mem_rvalid_i = 0; mem_err_i = 0;

        // Reset with two outstanding, then responses are spurious
        do_reset();
        req_i = 2'b01; mem_gnt_i = 1; addr[0] = 32'h80;
        settle();
        cyc();
        settle();
        chk("sp_second_gnt", gnt_o, 2'b01);
        cyc();
        rst_ni = 1'b0; req_i = 0; mem_gnt_i = 0;
        settle();
        chk("sp_rst_mem_req", mem_req_o, 0);
        cyc();
        rst_ni = 1'b1;
        for (int c = 0; c < 2; c++) begin
            mem_rvalid_i = 1;
            settle();
            chk($sformatf("sp_rvalid%0d", c), rvalid_o, 0);
            cyc();
        end
        mem_rvalid_i = 0;
        settle();
        chk("sp_flag_set", spurious_o, 1);
        chk("sp_rvalid_quiet", rvalid_o, 0);
        cyc();
        settle();
        chk("sp_flag_sticky", spurious_o, 1);
        cyc();
        rst_ni = 1'b0;
        settle();
        chk("sp_flag_cleared", spurious_o, 0);
        cyc();
        rst_ni = 1'b1;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
